// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment table for the 7-segment scan driver.
// Segment vectors are active low, bit 6 = g down to bit 0 = a.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  function automatic seg_t hex2seg(input logic [3:0] h);
    seg_t s;
    case (h)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b0100111;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// Refresh prescaler: mod-DIV counter, tick is high during the last count.
module seg7_prescaler #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_reg;
  logic [W-1:0] cnt_next;

  always_comb begin
    cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment driver; new values are latched only at
// frame boundaries so a frame always shows one coherent value.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NDIGITS = 4,
  parameter int CLK_DIV = 50000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4*NDIGITS-1:0]   in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   lzs,
  input  logic                   blank,
  output logic [6:0]             seg_n,
  output logic [NDIGITS-1:0]     an_n,
  output logic                   frame_done
);

  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIGITS - 1);
  localparam logic [NDIGITS-1:0] ONE_HOT0 = NDIGITS'(1);

  logic                 tick;
  logic                 boundary;
  logic                 suppress;
  logic [IW-1:0]        idx_reg;
  logic [IW-1:0]        idx_next;
  logic [4*NDIGITS-1:0] display_reg;
  logic [4*NDIGITS-1:0] pend_val_reg;
  logic                 pending_reg;
  logic                 frame_done_reg;
  seg_t                 seg_n_reg;
  logic [NDIGITS-1:0]   an_n_reg;
  logic [3:0]           digit [NDIGITS];
  logic [NDIGITS-1:0]   upper_zero;

  seg7_prescaler #(
    .DIV (CLK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // upper_zero[k]: digits NDIGITS-1 down to k of the shown value are all zero.
  generate
    for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_digit
      assign digit[gi]      = display_reg[4*gi +: 4];
      assign upper_zero[gi] = ~|display_reg[4*NDIGITS-1 : 4*gi];
    end
  endgenerate

  always_comb begin
    idx_next = idx_reg;
    if (tick) begin
      idx_next = (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
    end
  end

  assign boundary = tick && (idx_reg == LAST_IDX);
  assign suppress = lzs && (idx_reg != '0) && upper_zero[idx_reg];

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_reg        <= '0;
      display_reg    <= '0;
      pend_val_reg   <= '0;
      pending_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
      seg_n_reg      <= SEG_BLANK;
      an_n_reg       <= '1;
    end else begin
      idx_reg        <= idx_next;
      frame_done_reg <= boundary;
      // Swap and accept are exclusive: a swap needs pending, an accept needs !pending.
      if (boundary && pending_reg) begin
        display_reg <= pend_val_reg;
        pending_reg <= 1'b0;
      end else if (in_valid && !pending_reg) begin
        pend_val_reg <= in_data;
        pending_reg  <= 1'b1;
      end
      if (blank || suppress) begin
        seg_n_reg <= SEG_BLANK;
        an_n_reg  <= '1;
      end else begin
        seg_n_reg <= hex2seg(digit[idx_reg]);
        an_n_reg  <= ~(ONE_HOT0 << idx_reg);
      end
    end
  end

  assign in_ready   = !pending_reg;
  assign seg_n      = seg_n_reg;
  assign an_n       = an_n_reg;
  assign frame_done = frame_done_reg;

endmodule
